// File: rtl/freq_meter_core.sv
// freq_meter_core: counts rising edges of an async input over a gate window,
// optional /PRESCALE range, then converts the count to packed BCD for display.
// Ports: sysclk, rst (sync, active high), sigin (async), range (0:x1, 1:/PRESCALE);
//        bcd/ovf/rangedisp hold the last result, valid strobes on update, busy outside GATE.
module freq_meter_core #(
   parameter int GATE_CYCLES = 50_000_000,
   parameter int CNT_W       = 21,
   parameter int DIGITS      = 4,
   parameter int PRESCALE    = 10
) (
   input  logic                sysclk,
   input  logic                rst,
   input  logic                sigin,
   input  logic                range,
   output logic [4*DIGITS-1:0] bcd,
   output logic                valid,
   output logic                ovf,
   output logic                rangedisp,
   output logic                busy
);

   localparam int TMR_W = $clog2(GATE_CYCLES);
   localparam int PSC_W = $clog2(PRESCALE);
   localparam int BIT_W = $clog2(CNT_W);
   localparam int BCD_W = 4 * DIGITS;

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CNT_W - 1);
   localparam logic [BCD_W-1:0] NINES    = {DIGITS{4'h9}};

   typedef enum logic [1:0] {
      ST_GATE,
      ST_CONVERT,
      ST_UPDATE
   } state_t;

   state_t state;
   state_t state_nx;

   logic             sync1, sync2, sync3;
   logic             edge_det;
   logic [TMR_W-1:0] timer;
   logic [PSC_W-1:0] presc;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [BIT_W-1:0] bit_cnt;
   logic [BCD_W-1:0] acc;
   logic [BCD_W-1:0] adj;
   logic [BCD_W-1:0] acc_nx;
   logic             ovf_n;
   logic             ovf_nx;
   logic             rng_q;
   logic             abort;
   logic             gate_end;
   logic             conv_end;
   logic             pulse;

   assign edge_det = sync2 & ~sync3;
   assign abort    = (state == ST_GATE) && (range != rng_q);
   assign gate_end = (state == ST_GATE) && !abort && (timer == TMR_LAST);
   assign conv_end = (state == ST_CONVERT) && (bit_cnt == BIT_LAST);
   assign pulse    = (state == ST_GATE) && !abort && edge_det &&
                     (!rng_q || (presc == PSC_LAST));
   assign cnt_nx   = (pulse && (cnt != '1)) ? cnt + 1'b1 : cnt;

   // Shift-add-3 step. A bit leaving the top digit means the count needs
   // more digits than are shown, which is exactly the overflow condition.
   always_comb begin
      adj = acc;
      for (int d = 0; d < DIGITS; d++) begin
         if (adj[4*d +: 4] >= 4'd5)
            adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
      end
      acc_nx = {adj[BCD_W-2:0], cnt[CNT_W-1]};
      ovf_nx = ovf_n | adj[BCD_W-1];
   end

   always_ff @(posedge sysclk) begin
      if (rst)
         state <= ST_GATE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_GATE:    if (gate_end) state_nx = ST_CONVERT;
         ST_CONVERT: if (conv_end) state_nx = ST_UPDATE;
         ST_UPDATE:  state_nx = ST_GATE;
         default:    state_nx = ST_GATE;
      endcase
   end

   always_comb begin
      valid = 1'b0;
      busy  = 1'b0;
      unique case (state)
         ST_GATE: ;
         ST_CONVERT: busy = 1'b1;
         ST_UPDATE: begin
            busy  = 1'b1;
            valid = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         sync3     <= 1'b0;
         timer     <= '0;
         cnt       <= '0;
         presc     <= '0;
         bit_cnt   <= '0;
         acc       <= '0;
         ovf_n     <= 1'b0;
         rng_q     <= range;
         bcd       <= '0;
         ovf       <= 1'b0;
         rangedisp <= 1'b0;
      end else begin
         sync1 <= sigin;
         sync2 <= sync1;
         sync3 <= sync2;
         unique case (state)
            ST_GATE: begin
               if (abort) begin
                  timer <= '0;
                  cnt   <= '0;
                  presc <= '0;
                  rng_q <= range;
               end else begin
                  timer <= timer + 1'b1;
                  cnt   <= cnt_nx;
                  if (edge_det && rng_q)
                     presc <= (presc == PSC_LAST) ? '0 : presc + 1'b1;
                  if (gate_end) begin
                     acc     <= '0;
                     bit_cnt <= '0;
                     ovf_n   <= 1'b0;
                  end
               end
            end
            ST_CONVERT: begin
               acc     <= acc_nx;
               ovf_n   <= ovf_nx;
               cnt     <= {cnt[CNT_W-2:0], 1'b0};
               bit_cnt <= bit_cnt + 1'b1;
               // Load on the last shift so results show together with valid.
               if (conv_end) begin
                  bcd       <= ovf_nx ? NINES : acc_nx;
                  ovf       <= ovf_nx;
                  rangedisp <= rng_q;
               end
            end
            ST_UPDATE: begin
               timer <= '0;
               cnt   <= '0;
               presc <= '0;
               rng_q <= range;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_freq_meter_core.sv
// tb_freq_meter_core: directed and random stimulus for two freq_meter_core
// instances (4 and 2 digits) sharing inputs, checked against a window-count model.
module tb_freq_meter_core;

   localparam int GATE = 1000;
   localparam int CW   = 14;
   localparam int PS   = 10;
   localparam int PER  = GATE + CW + 1;

   logic        sysclk = 1'b0;
   logic        rst    = 1'b1;
   logic        sigin  = 1'b0;
   logic        range  = 1'b0;
   logic [15:0] bcd4;
   logic        valid4, ovf4, rd4, busy4;
   logic [7:0]  bcd2;
   logic        valid2, ovf2, rd2, busy2;

   always #5 sysclk = ~sysclk;

   freq_meter_core #(
      .GATE_CYCLES(GATE), .CNT_W(CW), .DIGITS(4), .PRESCALE(PS)
   ) dut4 (
      .sysclk(sysclk), .rst(rst), .sigin(sigin), .range(range),
      .bcd(bcd4), .valid(valid4), .ovf(ovf4), .rangedisp(rd4), .busy(busy4)
   );

   freq_meter_core #(
      .GATE_CYCLES(GATE), .CNT_W(CW), .DIGITS(2), .PRESCALE(PS)
   ) dut2 (
      .sysclk(sysclk), .rst(rst), .sigin(sigin), .range(range),
      .bcd(bcd2), .valid(valid2), .ovf(ovf2), .rangedisp(rd2), .busy(busy2)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int edge_n   = 0;
   bit rise [int];

   int          win_start = 0;
   logic        win_rng   = 1'b0;
   logic [15:0] e_bcd4    = '0;
   logic [7:0]  e_bcd2    = '0;
   logic        e_ovf4    = 1'b0;
   logic        e_ovf2    = 1'b0;
   logic        e_rd      = 1'b0;
   logic        e_valid   = 1'b0;
   logic        e_busy    = 1'b0;

   bit gen_on   = 1'b0;
   bit rnd_mode = 1'b0;
   int hi_len   = 5;
   int lo_len   = 5;
   int ph_cnt   = 0;

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Rising transitions driven after edge e are counted at edge e+3;
   // the window counts edges W+1 .. W+GATE.
   function automatic int win_count(input int w);
      int n;
      n = 0;
      for (int e = w + 1; e <= w + GATE; e++)
         if (rise.exists(e - 3)) n++;
      return n;
   endfunction

   task automatic set_sig(input logic v);
      if (v && !sigin) rise[edge_n] = 1'b1;
      sigin = v;
   endtask

   task automatic model_edge();
      int p;
      int n;
      logic [15:0] t;
      p = edge_n - win_start;
      if (rst) begin
         win_start = edge_n;
         win_rng   = range;
         e_bcd4 = '0; e_bcd2 = '0;
         e_ovf4 = 1'b0; e_ovf2 = 1'b0; e_rd = 1'b0;
      end else if (p >= 1 && p <= GATE && range !== win_rng) begin
         win_start = edge_n;
         win_rng   = range;
      end else if (p == PER) begin
         win_start = edge_n;
         win_rng   = range;
      end else if (p == PER - 1) begin
         n = win_count(win_start);
         if (win_rng) n = n / PS;
         if (n > (1 << CW) - 1) n = (1 << CW) - 1;
         t = to_bcd(n);
         e_ovf4 = (n >= 10000);
         e_ovf2 = (n >= 100);
         e_bcd4 = e_ovf4 ? 16'h9999 : t;
         e_bcd2 = e_ovf2 ? 8'h99 : t[7:0];
         e_rd   = win_rng;
      end
      e_valid = ((edge_n - win_start) == PER - 1);
      e_busy  = ((edge_n - win_start) >= GATE);
   endtask

   task automatic tick();
      @(posedge sysclk);
      edge_n++;
      model_edge();
      #1;
      check("valid4", 16'(valid4), 16'(e_valid));
      check("valid2", 16'(valid2), 16'(e_valid));
      check("busy4", 16'(busy4), 16'(e_busy));
      check("busy2", 16'(busy2), 16'(e_busy));
      check("bcd4", bcd4, e_bcd4);
      check("bcd2", 16'(bcd2), 16'(e_bcd2));
      check("ovf4", 16'(ovf4), 16'(e_ovf4));
      check("ovf2", 16'(ovf2), 16'(e_ovf2));
      check("rd4", 16'(rd4), 16'(e_rd));
      check("rd2", 16'(rd2), 16'(e_rd));
      if (gen_on) begin
         ph_cnt++;
         if (ph_cnt >= (sigin ? hi_len : lo_len)) begin
            ph_cnt = 0;
            if (rnd_mode) begin
               hi_len = $urandom_range(2, 9);
               lo_len = $urandom_range(2, 9);
            end
            set_sig(!sigin);
         end
      end
   endtask

   task automatic run_to_phase(input int ph, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while ((edge_n - win_start) != ph && n < 3 * PER);
      n_assert++;
      if ((edge_n - win_start) != ph) begin
         n_fail++;
         $display("FAIL phase_timeout: observed %0d expected %0d",
                  edge_n - win_start, ph);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [15:0] prev;

      rst = 1'b1;
      range = 1'b0;
      repeat (3) tick();
      check("rst_bcd4", bcd4, 16'h0000);
      check("rst_valid", 16'(valid4), 16'h0);
      check("rst_busy", 16'(busy4), 16'h0);
      check("rst_ovf", 16'(ovf4), 16'h0);
      rst = 1'b0;

      // Steady period 10, range 0
      gen_on = 1'b1;
      ph_cnt = 0;
      run_to_phase(PER - 1, n);
      check("t1_first_latency", 16'(n), 16'(PER - 1));
      run_to_phase(PER - 1, n);
      check("t1_period", 16'(n), 16'(PER));
      check("t1_bcd4", bcd4, 16'h0100);
      check("t1_ovf4", 16'(ovf4), 16'h0);
      check("t1_bcd2_limit", 16'(bcd2), 16'h0099);
      check("t1_ovf2_limit", 16'(ovf2), 16'h1);

      // Same signal, range 1
      range = 1'b1;
      run_to_phase(PER - 1, n);
      prev = bcd4;
      run_to_phase(PER - 1, n);
      check("t2_bcd4", bcd4, 16'h0010);
      check("t2_rd", 16'(rd4), 16'h1);
      check("t2_stable", bcd4, prev);

      // Period 6 then period 20
      range = 1'b0;
      hi_len = 3;
      lo_len = 3;
      run_to_phase(PER - 1, n);
      run_to_phase(PER - 1, n);
      check("t3_bcd2_ovf", 16'(bcd2), 16'h0099);
      check("t3_ovf2", 16'(ovf2), 16'h1);
      hi_len = 10;
      lo_len = 10;
      run_to_phase(PER - 1, n);
      run_to_phase(PER - 1, n);
      check("t3_bcd2", 16'(bcd2), 16'h0050);
      check("t3_ovf2_clr", 16'(ovf2), 16'h0);

      // Range toggle mid-gate
      hi_len = 5;
      lo_len = 5;
      run_to_phase(500, n);
      range = 1'b1;
      run_to_phase(PER - 1, n);
      check("t4_latency", 16'(n), 16'(PER));
      check("t4_rd", 16'(rd4), 16'h1);

      // Reset mid-convert
      gen_on = 1'b0;
      set_sig(1'b0);
      run_to_phase(GATE + 2, n);
      range = 1'b0;
      run_to_phase(GATE + 5, n);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_bcd4", bcd4, 16'h0000);
      check("t5_rd", 16'(rd4), 16'h0);
      check("t5_busy", 16'(busy4), 16'h0);
      gen_on = 1'b1;
      ph_cnt = 0;
      run_to_phase(PER - 1, n);
      check("t5_latency", 16'(n), 16'(PER - 1));

      // Single edge at the last gate cycle, then at the first dead cycle
      gen_on = 1'b0;
      set_sig(1'b0);
      run_to_phase(PER - 1, n);
      run_to_phase(GATE - 3, n);
      set_sig(1'b1);
      repeat (3) tick();
      set_sig(1'b0);
      run_to_phase(PER - 1, n);
      check("t6_last_bcd4", bcd4, 16'h0001);
      check("t6_last_bcd2", 16'(bcd2), 16'h0001);
      run_to_phase(GATE - 2, n);
      set_sig(1'b1);
      repeat (3) tick();
      set_sig(1'b0);
      run_to_phase(PER - 1, n);
      check("t6_dead_bcd4", bcd4, 16'h0000);

      // Random signal and random range changes
      rnd_mode = 1'b1;
      gen_on = 1'b1;
      ph_cnt = 0;
      for (int w = 0; w < 5; w++) begin
         run_to_phase($urandom_range(0, GATE - 1), n);
         range = 1'($urandom_range(0, 1));
         run_to_phase(PER - 1, n);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
